// File: rtl/inert_pkg.sv
// ---------------------------------------------------------------------------
// inert_pkg
// Shared types and helpers for the inertial-sensor SPI sequencer.
//   state_t  : sequencer FSM states
//   RD_FLAG  : MSB of a 16-bit SPI command word that marks a register read
//   rd_cmd() : builds a read command {RD_FLAG, addr[6:0], 8'h00}
// ---------------------------------------------------------------------------
package inert_pkg;

  typedef enum logic [2:0] {
    INIT_GAP = 3'd0,  // spacing delay before each config write
    INIT_WR  = 3'd1,  // config write outstanding
    IDLE     = 3'd2,  // waiting for synchronised INT
    RD       = 3'd3,  // byte reads of one frame outstanding
    PUB      = 3'd4   // one-cycle publish of the staged frame
  } state_t;

  localparam logic RD_FLAG = 1'b1;

  // Register read: address in [14:8], dummy data byte in [7:0].
  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {RD_FLAG, addr, 8'h00};
  endfunction

endpackage

// File: rtl/inert_seq_n_int_sync.sv
// ---------------------------------------------------------------------------
// int_sync
// Two-flop synchroniser for an asynchronous level input. Both flops clear
// on reset, so the synchronised output starts low.
// Ports:
//   clk    in  system clock
//   rst_n  in  async active-low reset
//   d_i    in  asynchronous level
//   q_o    out synchronised level (2-cycle latency)
// ---------------------------------------------------------------------------
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/inert_seq_n.sv
// ---------------------------------------------------------------------------
// inert_seq_n
// SPI sequencer for the inertial sensor. After reset it issues NUM_INIT
// config writes from INIT_TBL (each preceded by a 2**INIT_GAP_W-1 cycle gap).
// Afterwards, every time the synchronised INT is high in IDLE it reads
// 2*NUM_CH bytes (channel N low/high at RD_BASE+2N / RD_BASE+2N+1) through
// the external SPI master, then publishes all channels at once and pulses vld.
//
// Optional build macro:
//   INT_WDOG_EN  - IDLE watchdog. After WDOG_CYC IDLE cycles without INT the
//                  block pulses wdog_err, drops init_done and re-runs the
//                  whole config sequence. Published data is kept.
//                  Undefined: wdog_err is tied low and IDLE waits forever.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   async active-low reset (also resets the SPI master)
//   INT        in   sensor data-ready, asynchronous level
//   done       in   SPI transaction complete, 1-cycle pulse
//   rd_data    in   [7:0] SPI read byte, valid while done=1
//   wrt        out  start SPI transaction, 1-cycle pulse
//   cmd        out  [15:0] SPI command, held from wrt until done
//   data       out  [16*NUM_CH-1:0] channel words, ch0 in [15:0]
//   vld        out  1-cycle pulse: new frame on data
//   init_done  out  config writes complete (sticky)
//   busy       out  frame read in progress
//   wdog_err   out  1-cycle pulse: watchdog trip
// ---------------------------------------------------------------------------
module inert_seq_n
  import inert_pkg::*;
#(
  parameter int                    NUM_CH     = 5,
  parameter logic [6:0]            RD_BASE    = 7'h22,
  parameter int                    NUM_INIT   = 4,
  parameter logic [16*NUM_INIT-1:0] INIT_TBL  = {16'h1460, 16'h1162, 16'h1062, 16'h0D02},
  parameter int                    INIT_GAP_W = 16,
  parameter int                    WDOG_CYC   = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   INT,
  input  logic                   done,
  input  logic [7:0]             rd_data,
  output logic                   wrt,
  output logic [15:0]            cmd,
  output logic [16*NUM_CH-1:0]   data,
  output logic                   vld,
  output logic                   init_done,
  output logic                   busy,
  output logic                   wdog_err
);

  // -------------------------------------------------------------------------
  // Parameter sanity
  // -------------------------------------------------------------------------
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("inert_seq_n: NUM_CH must be 1..16");
  end
  if (NUM_INIT < 1 || NUM_INIT > 8) begin : g_bad_num_init
    $error("inert_seq_n: NUM_INIT must be 1..8");
  end
  if (INIT_GAP_W < 1) begin : g_bad_gap_w
    $error("inert_seq_n: INIT_GAP_W must be at least 1");
  end
  if (WDOG_CYC < 2) begin : g_bad_wdog
    $error("inert_seq_n: WDOG_CYC must be at least 2");
  end

  localparam int NUM_BYTES = 2 * NUM_CH;
  localparam int BW        = $clog2(NUM_BYTES);
  localparam int IW        = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

  localparam logic [BW-1:0]         BYTE_LAST = BW'(NUM_BYTES - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_INIT - 1);
  // Last counter value of the gap; the counter visits 0..GAP_LAST, i.e.
  // 2**INIT_GAP_W-1 cycles, and the write is launched on the last one.
  localparam logic [INIT_GAP_W-1:0] GAP_LAST  = INIT_GAP_W'((2 ** INIT_GAP_W) - 2);

  // -------------------------------------------------------------------------
  // INT synchroniser
  // -------------------------------------------------------------------------
  logic int_s;

  int_sync u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (INT),
    .q_o   (int_s)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                  state_q,     state_d;
  logic [IW-1:0]           idx_q,       idx_d;
  logic [INIT_GAP_W-1:0]   gap_q,       gap_d;
  logic [BW-1:0]           byte_q,      byte_d;
  logic                    pend_q,      pend_d;       // transaction outstanding
  logic                    wrt_q,       wrt_d;
  logic [15:0]             cmd_q,       cmd_d;
  logic [16*NUM_CH-1:0]    data_q,      data_d;
  logic                    vld_q,       vld_d;
  logic                    init_done_q, init_done_d;
  logic                    busy_q,      busy_d;

  logic [7:0]              stage_q [NUM_BYTES];
  logic                    stage_we;
  logic [16*NUM_CH-1:0]    stage_flat;
  logic                    done_ok;

`ifdef INT_WDOG_EN
  localparam int               WD_W    = $clog2(WDOG_CYC);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYC - 1);

  logic [WD_W-1:0] wd_q,       wd_d;
  logic            wdog_err_q, wdog_err_d;
`endif

  // A done only counts when it answers a wrt we issued; stray pulses are
  // dropped regardless of state.
  assign done_ok = done & pend_q;

  // Staging bytes flattened into channel order (byte 2N = low, 2N+1 = high).
  always_comb begin
    stage_flat = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      stage_flat[8*i +: 8] = stage_q[i];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    byte_d      = byte_q;
    pend_d      = pend_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    data_d      = data_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    stage_we    = 1'b0;
`ifdef INT_WDOG_EN
    wdog_err_d  = 1'b0;
`endif

    unique case (state_q)
      INIT_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          wrt_d   = 1'b1;
          pend_d  = 1'b1;
          cmd_d   = INIT_TBL[16*idx_q +: 16];
          state_d = INIT_WR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      INIT_WR: begin
        if (done_ok) begin
          pend_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            idx_d       = '0;
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = INIT_GAP;
          end
        end
      end

      IDLE: begin
        if (int_s) begin
          wrt_d   = 1'b1;
          pend_d  = 1'b1;
          cmd_d   = rd_cmd(RD_BASE);
          busy_d  = 1'b1;
          byte_d  = '0;
          state_d = RD;
        end
`ifdef INT_WDOG_EN
        else if (wd_q == WD_LAST) begin
          // Sensor went quiet: assume it lost its configuration.
          wdog_err_d  = 1'b1;
          init_done_d = 1'b0;
          idx_d       = '0;
          gap_d       = '0;
          state_d     = INIT_GAP;
        end
`endif
      end

      RD: begin
        if (done_ok) begin
          pend_d   = 1'b0;
          stage_we = 1'b1;
          if (byte_q != BYTE_LAST) begin
            wrt_d  = 1'b1;
            pend_d = 1'b1;
            // 7-bit address arithmetic, wraps modulo 128 by width.
            cmd_d  = rd_cmd(RD_BASE + 7'(byte_q) + 7'd1);
            byte_d = byte_q + 1'b1;
          end else begin
            state_d = PUB;
          end
        end
      end

      PUB: begin
        data_d  = stage_flat;
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = INIT_GAP;
    endcase

`ifdef INT_WDOG_EN
    // Counts consecutive IDLE cycles; any exit from IDLE restarts it.
    wd_d = (state_q == IDLE && state_d == IDLE) ? wd_q + 1'b1 : '0;
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_GAP;
      idx_q       <= '0;
      gap_q       <= '0;
      byte_q      <= '0;
      pend_q      <= 1'b0;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      data_q      <= '0;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      byte_q      <= byte_d;
      pend_q      <= pend_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the staging array is deliberately not reset; it is fully rewritten
  // before every publish, so a reset would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (stage_we) begin
      stage_q[byte_q] <= rd_data;
    end
  end

`ifdef INT_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q       <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wd_q       <= wd_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inert_seq_n.sv
// ---------------------------------------------------------------------------
// tb_inert_seq_n
// Directed bench for inert_seq_n with INIT_GAP_W=4 (15-cycle gaps) and
// WDOG_CYC=1000. A small SPI master model answers each wrt 4 cycles later;
// read bytes are frame_base + (addr - 0x22) + 1, so a frame with base 0x00
// returns 01..0A. Built with or without INT_WDOG_EN.
// ---------------------------------------------------------------------------
module tb_inert_seq_n;

  localparam int NUM_CH = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  INT = 1'b0;
  logic                  done;
  logic [7:0]            rd_data;
  logic                  wrt;
  logic [15:0]           cmd;
  logic [16*NUM_CH-1:0]  data;
  logic                  vld;
  logic                  init_done;
  logic                  busy;
  logic                  wdog_err;

  always #5 clk = ~clk;

  inert_seq_n #(
    .NUM_CH     (NUM_CH),
    .RD_BASE    (7'h22),
    .NUM_INIT   (4),
    .INIT_TBL   (64'h1460_1162_1062_0D02),
    .INIT_GAP_W (4),
    .WDOG_CYC   (1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .cmd       (cmd),
    .data      (data),
    .vld       (vld),
    .init_done (init_done),
    .busy      (busy),
    .wdog_err  (wdog_err)
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // SPI master model and monitors (sample on posedge, pre-update values)
  // -------------------------------------------------------------------------
  int          cyc = 0;
  logic [7:0]  frame_base = 8'h00;
  logic [15:0] log_cmd [$];
  int          log_cyc [$];
  int          done_cyc [$];
  logic        spi_busy;
  int          spi_cnt;
  logic [15:0] spi_cmd;
  int          overlap_err = 0;
  int          vld_cnt = 0;
  int          wdog_cnt = 0;
  int          last_vld_cyc = 0;
  int          data_glitch = 0;
  logic [16*NUM_CH-1:0] data_prev = '0;

  function automatic logic [7:0] model_byte(input logic [15:0] c);
    logic [7:0] k;
    if (!c[15]) return 8'h00;
    k = {1'b0, c[14:8] - 7'h22};
    return frame_base + k + 8'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy <= 1'b0;
      spi_cnt  <= 0;
      spi_cmd  <= 16'h0000;
      done     <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      if (done) done_cyc.push_back(cyc);
      if (wrt) begin
        if (spi_busy) overlap_err <= overlap_err + 1;
        log_cmd.push_back(cmd);
        log_cyc.push_back(cyc);
        spi_busy <= 1'b1;
        spi_cnt  <= 3;
        spi_cmd  <= cmd;
      end else if (spi_busy) begin
        if (spi_cnt == 1) begin
          done     <= 1'b1;
          rd_data  <= model_byte(spi_cmd);
          spi_busy <= 1'b0;
        end
        spi_cnt <= spi_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vld) begin
      vld_cnt      <= vld_cnt + 1;
      last_vld_cyc <= cyc;
    end
    if (wdog_err) wdog_cnt <= wdog_cnt + 1;
    // data may only move together with a vld pulse (or by reset).
    if (rst_n && !vld && data !== data_prev) data_glitch <= data_glitch + 1;
    data_prev <= data;
  end

  // -------------------------------------------------------------------------
  // Bounded waits (checked on negedge)
  // -------------------------------------------------------------------------
  task automatic clear_logs();
    log_cmd.delete();
    log_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic wait_init(input int bound, input string tag);
    int n = 0;
    while (!init_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, init_done, 1'b1);
  endtask

  task automatic wait_log(input int size, input int bound, input string tag);
    int n = 0;
    while (log_cmd.size() < size && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, log_cmd.size() >= size, 1'b1);
  endtask

  task automatic wait_dones(input int size, input int bound, input string tag);
    int n = 0;
    while (done_cyc.size() < size && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_cyc.size() >= size, 1'b1);
  endtask

  task automatic wait_vld(input int prev, input int bound, input string tag);
    int n = 0;
    while (vld_cnt <= prev && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, vld_cnt > prev, 1'b1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  localparam logic [79:0] F1 = 80'h0A09_0807_0605_0403_0201;
  localparam logic [79:0] F2 = 80'h1A19_1817_1615_1413_1211;
  logic [15:0] exp_init [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};

  initial begin
    int prev;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wrt",       wrt,       1'b0);
    check("rst_cmd",       cmd,       16'h0000);
    check("rst_data",      data,      80'h0);
    check("rst_flags",     {vld, init_done, busy, wdog_err}, 4'b0000);

    // Config sequence; 15 gap cycles separate each done from the next wrt,
    // so the model sees wrt 16 posedges after it saw done.
    rst_n = 1'b1;
    wait_init(400, "init_done_rise");
    check("init_wr_count", log_cmd.size(), 4);
    check("init_done_after_4th", done_cyc.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("init_cmd%0d", i), log_cmd[i], exp_init[i]);
    for (int i = 1; i < 4; i++)
      check($sformatf("init_gap%0d", i), log_cyc[i] - done_cyc[i-1], 16);
    check("idle_busy", busy, 1'b0);

    // Frame 1: bytes 01..0A
    clear_logs();
    frame_base = 8'h00;
    prev = vld_cnt;
    INT = 1'b1;
    wait_log(1, 20, "f1_start");
    INT = 1'b0;
    wait_vld(prev, 300, "f1_vld");
    check("f1_ncmd", log_cmd.size(), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("f1_cmd%0d", i), log_cmd[i], 16'hA200 + 16'(i * 256));
    check("f1_data", data, F1);
    repeat (5) @(negedge clk);
    check("f1_one_vld", vld_cnt - prev, 1);
    check("f1_busy_clr", busy, 1'b0);

    // Frame 2: bytes 11..1A, data must hold frame 1 mid-frame
    clear_logs();
    frame_base = 8'h10;
    prev = vld_cnt;
    INT = 1'b1;
    wait_log(1, 20, "f2_start");
    INT = 1'b0;
    wait_dones(5, 200, "f2_mid");
    check("f2_mid_data", data, F1);
    check("f2_mid_busy", busy, 1'b1);
    wait_vld(prev, 300, "f2_vld");
    check("f2_data", data, F2);
    check("data_only_on_vld", data_glitch, 0);

    // INT held high: no extra wrt mid-frame, next frame 1 cycle after vld
    clear_logs();
    frame_base = 8'h20;
    prev = vld_cnt;
    INT = 1'b1;
    wait_vld(prev, 300, "held_vld");
    check("held_ncmd", log_cmd.size(), 10);
    wait_log(11, 20, "held_next");
    check("held_next_dly", log_cyc[10] - last_vld_cyc, 1);
    check("held_next_cmd", log_cmd[10], 16'hA200);
    INT = 1'b0;
    prev = vld_cnt;
    wait_vld(prev, 300, "held_vld2");
    check("no_overlap", overlap_err, 0);

    // Reset during the 5th byte read
    clear_logs();
    frame_base = 8'h30;
    INT = 1'b1;
    wait_log(1, 20, "rst_f_start");
    INT = 1'b0;
    wait_log(5, 200, "rst_f_5th");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd",   cmd,  16'h0000);
    check("midrst_data",  data, 80'h0);
    check("midrst_flags", {wrt, vld, init_done, busy, wdog_err}, 5'b00000);
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    wait_log(1, 100, "reinit_start");
    check("reinit_cmd0", log_cmd[0], 16'h0D02);
    wait_init(400, "reinit_done");

    // Watchdog
    n = 0;
`ifdef INT_WDOG_EN
    while (!wdog_err && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wdog_delay", n, 1000);
    check("wdog_init_clr", init_done, 1'b0);
    clear_logs();
    wait_log(1, 100, "wdog_reinit");
    check("wdog_reinit_cmd", log_cmd[0], 16'h0D02);
    check("wdog_one_pulse", wdog_cnt, 1);
`else
    while (n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("no_wdog", wdog_cnt, 0);
    check("no_wdog_init", init_done, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
